fpmul_arbiter: RTL

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fpmul_arbiter.sv
// Two-requester round-robin front end for a shared two-stage floating-point
// multiplier pipeline. flpmult is the combinational IEEE-754 single multiplier:
// round-to-nearest-even, subnormal inputs and results flushed to signed zero,
// overflow to infinity, and every invalid case returns the canonical NaN 0xFFC00000.

module flpmult #(
   parameter int Bits = 32
) (
   input  logic [Bits-1:0] iA,
   input  logic [Bits-1:0] iB,
   output logic [Bits-1:0] oZ
);
   localparam int EW   = 8;
   localparam int FW   = Bits - 1 - EW;
   localparam int BIAS = 127;

   logic [EW-1:0]     w_ea, w_eb;
   logic [FW-1:0]     w_fa, w_fb;
   logic              w_s;
   logic              w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
   logic [2*FW+1:0]   w_prod;
   logic [EW+1:0]     w_esum;
   logic [FW-1:0]     w_mant;
   logic              w_guard, w_sticky;
   logic [EW+1:0]     w_exp;
   logic [FW:0]       w_rnd;
   logic [EW+1:0]     w_exp_r;

   assign w_ea     = iA[Bits-2:FW];
   assign w_eb     = iB[Bits-2:FW];
   assign w_fa     = iA[FW-1:0];
   assign w_fb     = iB[FW-1:0];
   assign w_s      = iA[Bits-1] ^ iB[Bits-1];
   assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
   assign w_b_nan  = (w_eb == '1) && (w_fb != '0);
   assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
   assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
   assign w_a_zero = (w_ea == '0);
   assign w_b_zero = (w_eb == '0);
   assign w_prod   = {1'b1, w_fa} * {1'b1, w_fb};
   assign w_esum   = {2'b00, w_ea} + {2'b00, w_eb} - (EW+2)'(BIAS);

   // Normalise the significand product, round to nearest even, pick special cases.
   always_comb begin
      w_mant   = '0;
      w_guard  = 1'b0;
      w_sticky = 1'b0;
      w_exp    = w_esum;
      if (w_prod[2*FW+1]) begin
         w_mant   = w_prod[2*FW:FW+1];
         w_guard  = w_prod[FW];
         w_sticky = |w_prod[FW-1:0];
         w_exp    = w_esum + (EW+2)'(1);
      end else begin
         w_mant   = w_prod[2*FW-1:FW];
         w_guard  = w_prod[FW-1];
         w_sticky = |w_prod[FW-2:0];
      end
      w_rnd   = {1'b0, w_mant} + (FW+1)'(w_guard & (w_sticky | w_mant[0]));
      // A carry out of rounding leaves the fraction at zero and bumps the exponent.
      w_exp_r = w_exp + (EW+2)'(w_rnd[FW]);
      if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
         oZ = {1'b1, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};
      else if (w_a_inf || w_b_inf)
         oZ = {w_s, {EW{1'b1}}, {FW{1'b0}}};
      else if (w_a_zero || w_b_zero)
         oZ = {w_s, {(Bits-1){1'b0}}};
      else if (w_exp_r[EW+1] || (w_exp_r == '0))
         oZ = {w_s, {(Bits-1){1'b0}}};
      else if (w_exp_r >= (EW+2)'((1 << EW) - 1))
         oZ = {w_s, {EW{1'b1}}, {FW{1'b0}}};
      else
         oZ = {w_s, w_exp_r[EW-1:0], w_rnd[FW-1:0]};
   end
endmodule

module fpmul_arbiter #(
   parameter int Bits = 32
) (
   input  logic            iClk,
   input  logic            iRst_n,
   input  logic            iReq0_valid,
   input  logic            iReq1_valid,
   input  logic [Bits-1:0] iA0,
   input  logic [Bits-1:0] iB0,
   input  logic [Bits-1:0] iA1,
   input  logic [Bits-1:0] iB1,
   output logic            oReq0_ready,
   output logic            oReq1_ready,
   output logic            oRes_valid,
   input  logic            iRes_ready,
   output logic [Bits-1:0] oZ,
   output logic            oRes_id,
   output logic            oBusy,
   output logic [15:0]     oCount
);
   logic            r_v1, r_v2, r_ptr, r_id1, r_id2;
   logic [Bits-1:0] r_a1, r_b1, r_z2;
   logic [15:0]     r_count;
   logic [Bits-1:0] w_z;
   logic            w_adv2, w_accept, w_grant0, w_grant1, w_take;

   flpmult #(.Bits(Bits)) u_flpmult (
      .iA (r_a1),
      .iB (r_b1),
      .oZ (w_z)
   );

   assign w_adv2      = r_v1 & (~r_v2 | iRes_ready);
   assign w_accept    = ~r_v1 | w_adv2;
   assign w_grant0    = iReq0_valid & (~iReq1_valid | ~r_ptr);
   assign w_grant1    = iReq1_valid & (~iReq0_valid |  r_ptr);
   assign oReq0_ready = w_accept & w_grant0;
   assign oReq1_ready = w_accept & w_grant1;
   assign w_take      = r_v2 & iRes_ready;
   assign oRes_valid  = r_v2;
   assign oZ          = r_z2;
   assign oRes_id     = r_id2;
   assign oBusy       = r_v1 | r_v2;
   assign oCount      = r_count;

   // Stage 1: capture the granted operand pair and rotate the priority pointer.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_v1  <= 1'b0;
         r_a1  <= '0;
         r_b1  <= '0;
         r_id1 <= 1'b0;
         r_ptr <= 1'b0;
      end else if (oReq0_ready || oReq1_ready) begin
         r_v1  <= 1'b1;
         r_a1  <= oReq1_ready ? iA1 : iA0;
         r_b1  <= oReq1_ready ? iB1 : iB0;
         r_id1 <= oReq1_ready;
         r_ptr <= oReq0_ready;
      end else if (w_adv2) begin
         r_v1  <= 1'b0;
      end
   end

   // Stage 2: register the product; hold it while the consumer stalls.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         r_v2  <= 1'b0;
         r_z2  <= '0;
         r_id2 <= 1'b0;
      end else if (w_adv2) begin
         r_v2  <= 1'b1;
         r_z2  <= w_z;
         r_id2 <= r_id1;
      end else if (w_take) begin
         r_v2  <= 1'b0;
      end
   end

   // Count delivered results, wrapping at 16 bits.
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n)
         r_count <= '0;
      else if (w_take)
         r_count <= r_count + 16'd1;
   end
endmodule
